scr1_tb_ahb_mmio: RTL and testbench

AHB-Lite slave on the dmem side of the simulation environment, decoded beside the main memory model, giving firmware a console TX channel, a test-status mailbox and a 64-bit cycle counter. The bench consumes its outputs for pass/fail detection and log printing, in place of PC/register probing. Console bytes are buffered in a FIFO and drained to a valid/ready sink. Address/data phases are pipelined per AHB-Lite, with wait states on FIFO full and two-cycle ERROR responses.

---
 rtl/scr1_tb_ahb_mmio.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_scr1_tb_ahb_mmio.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tb_ahb_mmio.sv
// -----------------------------------------------------------------------------
// scr1_tb_ahb_mmio
//
// AHB-Lite slave for the simulation environment. It sits beside the main
// memory model on the dmem bus and gives firmware three facilities:
//   - a console TX channel, buffered in a FIFO and drained to a valid/ready sink
//   - a test-status mailbox (done pulse + 31-bit code)
//   - a free-running, loadable 64-bit cycle counter
//
// Register map (offset = haddr[4:0], window of 32 bytes at BASE_ADDR):
//   0x00 CONSOLE     W: push byte lane haddr[1:0] of hwdata   R: FIFO count
//   0x04 TEST_STATUS W: word only, code = hwdata[31:1], done if hwdata[0]
//                    R: {test_code, 1'b0}
//   0x08 CYCLE_LO    R/W (word writes only)
//   0x0C CYCLE_HI    R/W (word writes only)
//
// Parameters:
//   BASE_ADDR  - base of the MMIO window, 32-byte aligned
//   FIFO_DEPTH - console FIFO entries, power of two, >= 2
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   hsel, htrans, haddr, hsize,
//   hwrite, hwdata                  AHB-Lite slave inputs
//   hready, hrdata, hresp           AHB-Lite slave outputs
//   con_valid, con_data, con_ready  console byte stream to the bench sink
//   test_done, test_code            test mailbox (done is a one-cycle pulse)
//   cycle_cnt                       current 64-bit counter value
//   stall_pattern                   wait-state pattern (optional feature only)
//
// Optional feature, enabled by defining SCR1_TB_MMIO_STALL_EN:
//   Adds the stall_pattern input. A rotating copy inserts wait states at the
//   start of every data phase while its bit 0 is 0. Undefined: no extra waits.
// -----------------------------------------------------------------------------
module scr1_tb_ahb_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SCR1_TB_MMIO_STALL_EN
  input  logic [31:0] stall_pattern,
`endif
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  output logic        hready,
  output logic [31:0] hrdata,
  output logic        hresp,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        test_done,
  output logic [30:0] test_code,
  output logic [63:0] cycle_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // State names the kind of data phase currently in progress (IDLE = none).
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_STALL,
    ST_ERR1,
    ST_ERR2
  } state_t;

  typedef enum logic [1:0] {
    REG_CONSOLE = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CYC_LO  = 2'd2,
    REG_CYC_HI  = 2'd3
  } reg_t;

  state_t          state;
  reg_t            d_reg;
  logic [1:0]      d_lane;
  logic            d_write;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic [63:0]     cnt_q;
  logic [30:0]     code_q;
  logic            done_q;

  logic            addr_err;
  logic            pat_hold;
  logic            in_data;
  logic            con_wr;
  logic            fifo_full;
  logic            xfer_done;
  logic            wr_commit;
  logic            push;
  logic            pop;
  logic [7:0]      push_byte;

  // htrans[0] only separates IDLE from BUSY and NONSEQ from SEQ; this slave
  // treats both pairs alike.
  logic            unused_ok;
  assign unused_ok = htrans[0];

  // ---------------------------------------------------------------------------
  // Address-phase decode. Errors are detected here so the data phase can
  // start directly in ERR1.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic in_window;
    logic size_err;
    logic misaligned;
    logic nonword_wr;
    in_window  = (haddr[31:5] == BASE_ADDR[31:5]) && !haddr[4];
    size_err   = hsize > 3'd2;
    misaligned = ((hsize == 3'd1) && haddr[0]) ||
                 ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
    nonword_wr = hwrite && (haddr[3:2] != 2'b00) && (hsize != 3'd2);
    addr_err   = !in_window || size_err || misaligned || nonword_wr;
  end

  assign in_data   = (state != ST_IDLE);
  assign con_wr    = d_write && (d_reg == REG_CONSOLE);
  assign fifo_full = (count == DEPTH_C);

  // ---------------------------------------------------------------------------
  // Optional wait-state pattern
  // ---------------------------------------------------------------------------
`ifdef SCR1_TB_MMIO_STALL_EN
  logic [31:0] pat_rot;
  logic        pat_loaded;
  logic        pat_done;

  // The copy resets to all ones (no waits) and picks up stall_pattern on the
  // first clock after reset, so the reset value stays a constant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_rot    <= '1;
      pat_loaded <= 1'b0;
      pat_done   <= 1'b0;
    end else begin
      pat_loaded <= 1'b1;
      pat_rot    <= pat_loaded ? {pat_rot[0], pat_rot[31:1]} : stall_pattern;
      // pat_done remembers that this data phase already saw bit0 = 1, so the
      // later STALL/ERR cycles are not stretched by further zeros.
      if (xfer_done || (state == ST_ERR2))
        pat_done <= 1'b0;
      else if (in_data && pat_rot[0])
        pat_done <= 1'b1;
    end
  end

  assign pat_hold = in_data && !pat_done && !pat_rot[0];
`else
  assign pat_hold = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Bus response. Decoded only from flops (state, FIFO count, pattern), so
  // there is no combinational path from any input to hready/hresp/hrdata.
  // ---------------------------------------------------------------------------
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    unique case (state)
      ST_IDLE:   hready = 1'b1;
      ST_ACCESS,
      ST_STALL:  hready = !pat_hold && !(con_wr && fifo_full);
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = !pat_hold;
      end
      ST_ERR2: begin
        hready = 1'b1;
        hresp  = 1'b1;
      end
      default:   hready = 1'b1;
    endcase
  end

  assign xfer_done = hready && ((state == ST_ACCESS) || (state == ST_STALL));
  assign wr_commit = xfer_done && d_write;
  assign push      = wr_commit && (d_reg == REG_CONSOLE);
  assign pop       = con_valid && con_ready;

  always_comb begin
    hrdata = 32'h0;
    if (((state == ST_ACCESS) || (state == ST_STALL)) && !d_write) begin
      unique case (d_reg)
        REG_CONSOLE: hrdata = 32'(count);
        REG_STATUS:  hrdata = {code_q, 1'b0};
        REG_CYC_LO:  hrdata = cnt_q[31:0];
        REG_CYC_HI:  hrdata = cnt_q[63:32];
        default:     hrdata = 32'h0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM. A new address phase is sampled in every cycle with
  // hready = 1, which gives back-to-back transfers including out of ERR2.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      d_reg   <= REG_CONSOLE;
      d_lane  <= 2'b00;
      d_write <= 1'b0;
    end else if (hready) begin
      if (hsel && htrans[1]) begin
        state   <= addr_err ? ST_ERR1 : ST_ACCESS;
        d_reg   <= reg_t'(haddr[3:2]);
        d_lane  <= haddr[1:0];
        d_write <= hwrite;
      end else begin
        state   <= ST_IDLE;
      end
    end else begin
      // Not ready: either a pattern wait, a full FIFO, or the first error
      // cycle. The FSM advances only once the pattern wait is over.
      unique case (state)
        ST_ACCESS: if (!pat_hold) state <= ST_STALL;
        ST_ERR1:   if (!pat_hold) state <= ST_ERR2;
        default:   state <= state;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Console FIFO
  // ---------------------------------------------------------------------------
  assign push_byte = hwdata[{d_lane, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only observed once
  // written, and con_data is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_byte;
  end

  assign con_valid = (count != '0);
  assign con_data  = con_valid ? fifo_mem[rd_ptr] : 8'h00;

  // ---------------------------------------------------------------------------
  // Test mailbox and cycle counter. Writes land at the end of the data phase.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= wr_commit && (d_reg == REG_STATUS) && hwdata[0];
      if (wr_commit && (d_reg == REG_STATUS))
        code_q <= hwdata[31:1];

      // A load replaces the increment for that cycle; the other half holds.
      if (wr_commit && (d_reg == REG_CYC_LO))
        cnt_q <= {cnt_q[63:32], hwdata};
      else if (wr_commit && (d_reg == REG_CYC_HI))
        cnt_q <= {hwdata, cnt_q[31:0]};
      else
        cnt_q <= cnt_q + 64'd1;
    end
  end

  assign test_done = done_q;
  assign test_code = code_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_scr1_tb_ahb_mmio.sv
// -----------------------------------------------------------------------------
// tb_scr1_tb_ahb_mmio
//
// Directed bench for scr1_tb_ahb_mmio. Inputs are driven on the falling edge,
// DUT outputs are sampled on the falling edge (away from the rising edge
// where the DUT updates). A small sink monitor collects console bytes.
// -----------------------------------------------------------------------------
module tb_scr1_tb_ahb_mmio;

  localparam logic [31:0] BASE = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [31:0] haddr = 32'h0;
  logic [2:0]  hsize = 3'd0;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = 32'h0;
  logic        hready;
  logic [31:0] hrdata;
  logic        hresp;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready = 1'b0;
  logic        test_done;
  logic [30:0] test_code;
  logic [63:0] cycle_cnt;

  int errors = 0;
  int checks = 0;
  logic [7:0] sink_q[$];

  scr1_tb_ahb_mmio #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef SCR1_TB_MMIO_STALL_EN
    .stall_pattern (32'hFFFF_FFFF),
`endif
    .hsel          (hsel),
    .htrans        (htrans),
    .haddr         (haddr),
    .hsize         (hsize),
    .hwrite        (hwrite),
    .hwdata        (hwdata),
    .hready        (hready),
    .hrdata        (hrdata),
    .hresp         (hresp),
    .con_valid     (con_valid),
    .con_data      (con_data),
    .con_ready     (con_ready),
    .test_done     (test_done),
    .test_code     (test_code),
    .cycle_cnt     (cycle_cnt)
  );

  always #5 clk = ~clk;

  // Sink: a byte is taken on the rising edge that follows a falling edge
  // where valid and ready are both high.
  always @(negedge clk) begin
    #1;
    if (rst_n && con_valid && con_ready) sink_q.push_back(con_data);
  end

  // One non-pipelined transfer, called and returning on a falling edge.
  task automatic ahb_xfer(input logic [31:0] addr, input logic [2:0] size,
                          input logic wr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int waits,
                          output logic first_resp, output logic resp);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hsize = size; hwrite = wr;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
    first_resp = hresp;
    waits = 0;
    while (hready !== 1'b1 && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    rdata = hrdata;
    resp  = hresp;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (hready !== 1'b1) begin errors++; $display("FAIL reset_hready got=%b exp=1", hready); end
    checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp got=%b exp=0", hresp); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata got=%h exp=0", hrdata); end
    checks++; if (con_valid !== 1'b0 || con_data !== 8'h0) begin errors++; $display("FAIL reset_console got=%b/%h exp=0/00", con_valid, con_data); end
    checks++; if (test_done !== 1'b0 || test_code !== 31'h0) begin errors++; $display("FAIL reset_mailbox got=%b/%h exp=0/0", test_done, test_code); end
    checks++; if (cycle_cnt !== 64'h0) begin errors++; $display("FAIL reset_cycle got=%h exp=0", cycle_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_console_basic();
    logic [31:0] rd; int w; logic fr, r;
    con_ready = 1'b1;
    ahb_xfer(BASE, 3'd2, 1'b1, 32'h0000_0041, rd, w, fr, r);
    checks++; if (w != 0) begin errors++; $display("FAIL con_basic_waits got=%0d exp=0", w); end
    checks++; if (con_valid !== 1'b1 || con_data !== 8'h41) begin errors++; $display("FAIL con_basic_byte got=%b/%h exp=1/41", con_valid, con_data); end
    @(negedge clk);
    checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL con_basic_one_cycle got=%b exp=0", con_valid); end
    ahb_xfer(BASE, 3'd2, 1'b0, 32'h0, rd, w, fr, r);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL con_basic_count got=%h exp=0", rd); end
    sink_q.delete();
  endtask

  task automatic test_console_full();
    logic [31:0] rd; int w; logic fr, r; int stalled; int n;
    con_ready = 1'b0;
    sink_q.delete();
    // Byte writes rotate through all four lanes.
    for (int i = 1; i <= 16; i++) begin
      ahb_xfer(BASE + 32'(i % 4), 3'd0, 1'b1, 32'(i) << (8 * (i % 4)), rd, w, fr, r);
      checks++; if (w != 0 || r !== 1'b0) begin errors++; $display("FAIL con_fill_%0d waits=%0d resp=%b exp=0/0", i, w, r); end
    end
    ahb_xfer(BASE, 3'd2, 1'b0, 32'h0, rd, w, fr, r);
    checks++; if (rd !== 32'd16) begin errors++; $display("FAIL con_full_count got=%0d exp=16", rd); end
    // 17th byte (lane 1) must stall while the sink holds off.
    hsel = 1'b1; htrans = 2'b10; haddr = BASE + 32'd1; hsize = 3'd0; hwrite = 1'b1;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'd17 << 8;
    stalled = 0;
    repeat (3) begin
      if (hready === 1'b0 && hresp === 1'b0) stalled++;
      @(negedge clk);
    end
    checks++; if (stalled != 3) begin errors++; $display("FAIL con_stall_cycles got=%0d exp=3", stalled); end
    con_ready = 1'b1;
    for (n = 0; n < 50 && hready !== 1'b1; n++) @(negedge clk);
    checks++; if (hready !== 1'b1) begin errors++; $display("FAIL con_stall_release got=%b exp=1", hready); end
    @(negedge clk);
    for (n = 0; n < 100 && sink_q.size() < 17; n++) @(negedge clk);
    checks++; if (sink_q.size() != 17) begin errors++; $display("FAIL con_sink_size got=%0d exp=17", sink_q.size()); end
    for (int i = 0; i < sink_q.size(); i++) begin
      checks++; if (sink_q[i] !== 8'(i + 1)) begin errors++; $display("FAIL con_sink_%0d got=%h exp=%h", i, sink_q[i], 8'(i + 1)); end
    end
    ahb_xfer(BASE, 3'd2, 1'b0, 32'h0, rd, w, fr, r);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL con_drained_count got=%0d exp=0", rd); end
  endtask

  task automatic test_status();
    logic [31:0] rd; int w; logic fr, r;
    ahb_xfer(BASE + 32'h4, 3'd2, 1'b1, 32'h0000_0001, rd, w, fr, r);
    checks++; if (test_done !== 1'b1 || test_code !== 31'd0) begin errors++; $display("FAIL status_done got=%b/%0d exp=1/0", test_done, test_code); end
    @(negedge clk);
    checks++; if (test_done !== 1'b0) begin errors++; $display("FAIL status_pulse_width got=%b exp=0", test_done); end
    ahb_xfer(BASE + 32'h4, 3'd2, 1'b1, 32'h0000_000B, rd, w, fr, r);
    checks++; if (test_code !== 31'd5) begin errors++; $display("FAIL status_code got=%0d exp=5", test_code); end
    ahb_xfer(BASE + 32'h4, 3'd2, 1'b0, 32'h0, rd, w, fr, r);
    checks++; if (rd !== 32'h0000_000A) begin errors++; $display("FAIL status_read got=%h exp=0000000a", rd); end
  endtask

  task automatic test_back_to_back();
    // Write TEST_STATUS then read it in the very next address phase.
    hsel = 1'b1; htrans = 2'b10; haddr = BASE + 32'h4; hsize = 3'd2; hwrite = 1'b1;
    @(negedge clk);
    hwdata = 32'h0000_0006; hwrite = 1'b0;
    checks++; if (hready !== 1'b1) begin errors++; $display("FAIL b2b_write_ready got=%b exp=1", hready); end
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    checks++; if (hrdata !== 32'h0000_0006 || test_done !== 1'b0) begin errors++; $display("FAIL b2b_read got=%h/%b exp=00000006/0", hrdata, test_done); end
    @(negedge clk);
    // Error transfer followed by a read accepted in ERR2.
    hsel = 1'b1; htrans = 2'b10; haddr = BASE + 32'h14; hsize = 3'd2; hwrite = 1'b0;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    checks++; if (hready !== 1'b0 || hresp !== 1'b1) begin errors++; $display("FAIL b2b_err1 got=%b/%b exp=0/1", hready, hresp); end
    @(negedge clk);
    checks++; if (hready !== 1'b1 || hresp !== 1'b1) begin errors++; $display("FAIL b2b_err2 got=%b/%b exp=1/1", hready, hresp); end
    hsel = 1'b1; htrans = 2'b10; haddr = BASE + 32'h4; hsize = 3'd2; hwrite = 1'b0;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00;
    checks++; if (hready !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h6) begin errors++; $display("FAIL b2b_after_err got=%b/%b/%h exp=1/0/00000006", hready, hresp, hrdata); end
    @(negedge clk);
  endtask

  task automatic test_cycle_wrap();
    logic [31:0] rd; int w; logic fr, r;
    ahb_xfer(BASE + 32'hC, 3'd2, 1'b1, 32'hFFFF_FFFF, rd, w, fr, r);
    ahb_xfer(BASE + 32'h8, 3'd2, 1'b1, 32'hFFFF_FFFD, rd, w, fr, r);
    checks++; if (cycle_cnt !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL cycle_load got=%h exp=fffffffffffffffd", cycle_cnt); end
    repeat (2) @(negedge clk);
    // FD -> FE -> all ones -> 0 on the edge that accepts the LO read.
    ahb_xfer(BASE + 32'h8, 3'd2, 1'b0, 32'h0, rd, w, fr, r);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cycle_lo_wrap got=%h exp=0", rd); end
    checks++; if (cycle_cnt !== 64'd1) begin errors++; $display("FAIL cycle_port_wrap got=%h exp=1", cycle_cnt); end
    ahb_xfer(BASE + 32'hC, 3'd2, 1'b0, 32'h0, rd, w, fr, r);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cycle_hi_wrap got=%h exp=0", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; int w; logic fr, r;
    logic [31:0] offs  [4] = '{32'h14, 32'h4, 32'h2, 32'h0};
    logic [2:0]  sizes [4] = '{3'd2, 3'd1, 3'd2, 3'd3};
    logic        wrs   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    ahb_xfer(BASE + 32'h4, 3'd2, 1'b1, 32'h0000_0014, rd, w, fr, r);
    for (int i = 0; i < 4; i++) begin
      ahb_xfer(BASE + offs[i], sizes[i], wrs[i], 32'h0000_0003, rd, w, fr, r);
      checks++; if (w != 1 || fr !== 1'b1 || r !== 1'b1 || rd !== 32'h0) begin
        errors++; $display("FAIL err_seq_%0d waits=%0d resp1=%b resp2=%b rdata=%h exp=1/1/1/0", i, w, fr, r, rd);
      end
    end
    checks++; if (test_code !== 31'd10 || test_done !== 1'b0) begin errors++; $display("FAIL err_code_kept got=%0d/%b exp=10/0", test_code, test_done); end
    checks++; if (hready !== 1'b1 || hresp !== 1'b0) begin errors++; $display("FAIL err_back_idle got=%b/%b exp=1/0", hready, hresp); end
  endtask

  task automatic test_reset_mid_stall();
    logic [31:0] rd; int w; logic fr, r;
    con_ready = 1'b0;
    for (int i = 1; i <= 16; i++) ahb_xfer(BASE, 3'd0, 1'b1, 32'(i), rd, w, fr, r);
    hsel = 1'b1; htrans = 2'b10; haddr = BASE; hsize = 3'd0; hwrite = 1'b1;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'd17;
    @(negedge clk);
    checks++; if (hready !== 1'b0) begin errors++; $display("FAIL rst_stall_pre got=%b exp=0", hready); end
    rst_n = 1'b0;
    #1;
    checks++; if (hready !== 1'b1 || hresp !== 1'b0) begin errors++; $display("FAIL rst_stall_bus got=%b/%b exp=1/0", hready, hresp); end
    checks++; if (con_valid !== 1'b0 || test_code !== 31'd0) begin errors++; $display("FAIL rst_stall_state got=%b/%0d exp=0/0", con_valid, test_code); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ahb_xfer(BASE, 3'd2, 1'b0, 32'h0, rd, w, fr, r);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rst_stall_count got=%0d exp=0", rd); end
  endtask

  initial begin
    test_reset();
    test_console_basic();
    test_console_full();
    test_status();
    test_back_to_back();
    test_cycle_wrap();
    test_errors();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
